// File: rtl/fifo_bist_ctrl.sv
// BIST sequencer for the FIFO dual-port memory: two-pass address-derived pattern write/read-back
// on WCLK, with a latency-matched compare pipeline and sticky pass/fail reporting.
module fifo_bist_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                  WCLK,
    input  logic                  RST,
    input  logic                  BIST_EN,
    input  logic [DATA_WIDTH-1:0] RDATA,
    output logic                  B_WEN,
    output logic [ADDR_WIDTH-1:0] B_WADDR,
    output logic [DATA_WIDTH-1:0] B_WDATA,
    output logic                  B_REN,
    output logic [ADDR_WIDTH-1:0] B_RADDR,
    output logic [DATA_WIDTH-1:0] EXPECTED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASSFAIL,
    output logic [ADDR_WIDTH-1:0] FAIL_ADDR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic                  pass, pass_nxt;
    logic [2:0]            drain_cnt, drain_nxt;
    logic [DATA_WIDTH-1:0] rd_pat;
    logic                  fail_flag;
    logic                  start;
    logic                  mismatch;

    logic                  pipe_valid [RD_LAT];
    logic [ADDR_WIDTH-1:0] pipe_addr  [RD_LAT];
    logic [DATA_WIDTH-1:0] pipe_data  [RD_LAT];

    // Address bits repeated LSB-first across the word, inverted on the second pass.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a, input logic p);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            d[i] = a[i % ADDR_WIDTH] ^ p;
        end
        return d;
    endfunction

    assign start    = (state == ST_IDLE) && BIST_EN;
    assign mismatch = pipe_valid[RD_LAT-1] && (RDATA != pipe_data[RD_LAT-1]);
    assign EXPECTED = pipe_data[RD_LAT-1];

    always_ff @(posedge WCLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            addr      <= '0;
            pass      <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            pass      <= pass_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        pass_nxt  = pass;
        drain_nxt = drain_cnt;
        case (state)
            ST_IDLE: begin
                if (BIST_EN) begin
                    state_nxt = ST_WRITE;
                    addr_nxt  = '0;
                    pass_nxt  = 1'b0;
                end
            end
            ST_WRITE: begin
                addr_nxt = addr + 1'b1;
                if (addr == '1) state_nxt = ST_READ;
            end
            ST_READ: begin
                addr_nxt = addr + 1'b1;
                if (addr == '1) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = '0;
                end
            end
            ST_DRAIN: begin
                drain_nxt = drain_cnt + 1'b1;
                if (drain_cnt == LAT_LAST) begin
                    drain_nxt = '0;
                    if (pass) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WRITE;
                        pass_nxt  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Dropping the enable abandons any run in progress.
        if (!BIST_EN) begin
            state_nxt = ST_IDLE;
            addr_nxt  = '0;
            pass_nxt  = 1'b0;
            drain_nxt = '0;
        end
    end

    // Strobes are gated by BIST_EN so an abort clears them on the same edge the FSM leaves.
    always_ff @(posedge WCLK or negedge RST) begin
        if (!RST) begin
            B_WEN     <= 1'b0;
            B_WADDR   <= '0;
            B_WDATA   <= '0;
            B_REN     <= 1'b0;
            B_RADDR   <= '0;
            rd_pat    <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASSFAIL  <= 1'b0;
            fail_flag <= 1'b0;
            FAIL_ADDR <= '0;
        end else begin
            B_WEN    <= BIST_EN && (state == ST_WRITE);
            B_WADDR  <= (BIST_EN && (state == ST_WRITE)) ? addr : '0;
            B_WDATA  <= (BIST_EN && (state == ST_WRITE)) ? pattern(addr, pass) : '0;
            B_REN    <= BIST_EN && (state == ST_READ);
            B_RADDR  <= (BIST_EN && (state == ST_READ)) ? addr : '0;
            rd_pat   <= (BIST_EN && (state == ST_READ)) ? pattern(addr, pass) : '0;
            BUSY     <= BIST_EN && ((state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN));
            DONE     <= BIST_EN && (state == ST_DONE);
            // The last compare lands on the same edge DONE rises, so fold it in directly.
            PASSFAIL <= BIST_EN && (state == ST_DONE) && !(fail_flag || mismatch);
            if (start) begin
                fail_flag <= 1'b0;
            end else if (mismatch) begin
                fail_flag <= 1'b1;
            end
            if (!BIST_EN || start) begin
                FAIL_ADDR <= '0;
            end else if (mismatch && !fail_flag) begin
                FAIL_ADDR <= pipe_addr[RD_LAT-1];
            end
        end
    end

    // Stage 0 captures the read issued on the previous cycle, as the memory samples it.
    always_ff @(posedge WCLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_addr[i]  <= '0;
                pipe_data[i]  <= '0;
            end
        end else if (!BIST_EN) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_addr[i]  <= '0;
                pipe_data[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= B_REN;
            pipe_addr[0]  <= B_RADDR;
            pipe_data[0]  <= rd_pat;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fifo_bist_ctrl.sv
// Bench for fifo_bist_ctrl: one instance with a 1-cycle memory (with stuck-bit injection) and one
// with a 3-stage memory; write streams and aligned expected words are scoreboarded against queues.
module tb_fifo_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN;
    logic       en1, en2;

    logic       wen1, ren1, busy1, done1, pf1;
    logic [3:0] waddr1, raddr1, fa1;
    logic [7:0] wdata1, exp1;
    logic [7:0] rdata1 = '0;

    logic       wen2, ren2, busy2, done2, pf2;
    logic [3:0] waddr2, raddr2, fa2;
    logic [7:0] wdata2, exp2, rdata2;

    logic [7:0] mem1 [16];
    logic [7:0] mem2 [16];
    logic [7:0] sa0  [16];
    logic [7:0] sa1  [16];
    logic [7:0] r2a = '0, r2b = '0, r2c = '0;
    logic       v2a = 1'b0, v2b = 1'b0, v2c = 1'b0;

    int testsRun  = 0;
    int failCount = 0;

    logic [11:0] wrQueue  [$];
    logic [7:0]  expQueue [$];

    fifo_bist_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_LAT(1)) u1 (
        .WCLK(clk), .RST(rstN), .BIST_EN(en1), .RDATA(rdata1),
        .B_WEN(wen1), .B_WADDR(waddr1), .B_WDATA(wdata1),
        .B_REN(ren1), .B_RADDR(raddr1), .EXPECTED(exp1),
        .BUSY(busy1), .DONE(done1), .PASSFAIL(pf1), .FAIL_ADDR(fa1)
    );

    fifo_bist_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_LAT(3)) u2 (
        .WCLK(clk), .RST(rstN), .BIST_EN(en2), .RDATA(rdata2),
        .B_WEN(wen2), .B_WADDR(waddr2), .B_WDATA(wdata2),
        .B_REN(ren2), .B_RADDR(raddr2), .EXPECTED(exp2),
        .BUSY(busy2), .DONE(done2), .PASSFAIL(pf2), .FAIL_ADDR(fa2)
    );

    function automatic logic [7:0] pat(input logic [3:0] a, input logic p);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = a[i % 4] ^ p;
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, actual, expected);
        end
    endtask

    // Memory models: single-cycle read with stuck-at injection, and a three-stage read pipe.
    always @(posedge clk) begin
        if (wen1) mem1[waddr1] <= wdata1;
        if (ren1) rdata1 <= (mem1[raddr1] & ~sa0[raddr1]) | sa1[raddr1];
        if (wen2) mem2[waddr2] <= wdata2;
        if (ren2) r2a <= mem2[raddr2];
        r2b <= r2a;
        r2c <= r2b;
        v2a <= ren2;
        v2b <= v2a;
        v2c <= v2b;
    end
    assign rdata2 = r2c;

    always @(negedge clk) begin
        logic [11:0] w;
        logic [7:0]  e;
        if (wen1) begin
            if (wrQueue.size() == 0) begin
                checkOutput("wr_unexpected", {31'd0, wen1}, 0);
            end else begin
                w = wrQueue.pop_front();
                checkOutput("wr_stream", {20'd0, waddr1, wdata1}, {20'd0, w});
            end
        end
        if (v2c) begin
            if (expQueue.size() == 0) begin
                checkOutput("cmp_unexpected", {31'd0, v2c}, 0);
            end else begin
                e = expQueue.pop_front();
                checkOutput("expected_align", {24'd0, exp2}, {24'd0, e});
                checkOutput("rdata_lat3", {24'd0, rdata2}, {24'd0, e});
            end
        end
    end

    task automatic applyStimulus(input int which);
        if (which == 1) begin
            wrQueue.delete();
            for (int p = 0; p < 2; p++)
                for (int a = 0; a < 16; a++)
                    wrQueue.push_back({4'(a), pat(4'(a), p[0])});
            en1 = 1'b1;
        end else begin
            expQueue.delete();
            for (int p = 0; p < 2; p++)
                for (int a = 0; a < 16; a++)
                    expQueue.push_back(pat(4'(a), p[0]));
            en2 = 1'b1;
        end
    endtask

    task automatic runCheck(input int which, input int expEdges, input logic expPass, input logic [3:0] expAddr);
        int   n;
        logic d;
        applyStimulus(which);
        @(posedge clk);
        n = 0;
        d = 1'b0;
        while (!d && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            d = (which == 1) ? done1 : done2;
            if (n == 20) checkOutput("busy_mid", {31'd0, (which == 1) ? busy1 : busy2}, 1);
        end
        checkOutput("done_edge", n, expEdges);
        checkOutput("passfail", {31'd0, (which == 1) ? pf1 : pf2}, {31'd0, expPass});
        checkOutput("fail_addr", {28'd0, (which == 1) ? fa1 : fa2}, {28'd0, expAddr});
        checkOutput("busy_at_done", {31'd0, (which == 1) ? busy1 : busy2}, 0);
        checkOutput("queue_left", (which == 1) ? wrQueue.size() : expQueue.size(), 0);
        if (which == 1) en1 = 1'b0; else en2 = 1'b0;
        @(negedge clk);
        checkOutput("done_drop", {31'd0, (which == 1) ? done1 : done2}, 0);
        checkOutput("passfail_drop", {31'd0, (which == 1) ? pf1 : pf2}, 0);
        checkOutput("fail_addr_drop", {28'd0, (which == 1) ? fa1 : fa2}, 0);
    endtask

    task automatic clearFaults();
        for (int a = 0; a < 16; a++) begin
            sa0[a] = '0;
            sa1[a] = '0;
        end
    endtask

    initial begin
        int   cnt;
        logic sawDone;
        rstN = 1'b0;
        en1  = 1'b0;
        en2  = 1'b0;
        clearFaults();
        for (int a = 0; a < 16; a++) begin
            mem1[a] = '0;
            mem2[a] = '0;
        end
        repeat (3) @(negedge clk);
        checkOutput("rst_outputs1", {wen1, ren1, busy1, done1, pf1, fa1, exp1, waddr1, wdata1}, 0);
        checkOutput("rst_outputs2", {wen2, ren2, busy2, done2, pf2, fa2, exp2, raddr2}, 0);
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] good memory, RD_LAT=1");
        runCheck(1, 67, 1'b1, 4'd0);

        $display("[TB] addr 5 bit 0 stuck at 0");
        sa0[5] = 8'h01;
        runCheck(1, 67, 1'b0, 4'd5);
        clearFaults();

        $display("[TB] faults at addr 9 (pass 0) and addr 2 (pass 1)");
        sa0[9] = 8'h01;
        sa1[2] = 8'h02;
        runCheck(1, 67, 1'b0, 4'd9);
        clearFaults();

        $display("[TB] abort on 10th read cycle");
        applyStimulus(1);
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 10; i++) begin
            @(negedge clk);
            if (ren1) cnt++;
        end
        checkOutput("abort_reached", cnt, 10);
        en1 = 1'b0;
        @(negedge clk);
        checkOutput("abort_strobes", {wen1, ren1, busy1, done1, pf1}, 0);
        sawDone = 1'b0;
        repeat (80) begin
            @(negedge clk);
            sawDone = sawDone | done1;
        end
        checkOutput("abort_no_done", {31'd0, sawDone}, 0);
        runCheck(1, 67, 1'b1, 4'd0);

        $display("[TB] reset pulse mid-write");
        applyStimulus(1);
        repeat (6) @(negedge clk);
        #2 rstN = 1'b0;
        #1 checkOutput("async_rst", {wen1, busy1, waddr1, wdata1, done1}, 0);
        @(negedge clk);
        rstN = 1'b1;
        runCheck(1, 67, 1'b1, 4'd0);

        $display("[TB] RD_LAT=3 instance");
        runCheck(2, 71, 1'b1, 4'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
